data_mem_arbiter: RTL and testbench

//  Shares the single-port data memory of RISC_V_Processor between two requesters:

---
 rtl/data_mem_arbiter_pkg.sv | 21 ++
 rtl/data_mem_arbiter_rr.sv | 30 +++
 rtl/data_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   mem_state_t : transaction FSM states (IDLE/ISSUE/WAIT/RESP)
//   DEF_ADDR_W  : default memory word address width
//   DEF_DATA_W  : default data width
//   PORT_CORE / PORT_DBG : requester indices (core load/store, readback/debug)
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 64;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Two-way request picker for the data-memory arbiter.
//   valid[1:0]  : pending requests (bit N = port N)
//   last_grant  : port that won the previous acceptance
//   grant[1:0]  : one-hot winner (combinational), 0 when nothing is pending
// PRIO_FIXED != 0 makes port 0 win every tie; otherwise ties go to the port
// that did not win last.
module rr_arbiter2
  import riscv_mem_pkg::*;
#(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if ((PRIO_FIXED != 0) || (last_grant == PORT_DBG)) grant = 2'b01;
        else                                               grant = 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the core load/store path
// (port 0) and the readback/debug path (port 1). One transaction in flight,
// registered memory-side outputs, fixed read latency MEM_LAT.
//   clk, reset                : rising-edge clock, async active-low reset
//   rN_valid/ready            : request handshake (ready is combinational)
//   rN_we/addr/wdata          : request payload, latched on acceptance
//   rN_rvalid/rdata           : one-cycle read-valid pulse, data held until next read on that port
//   mem_en/we/addr/wdata      : memory strobe and payload, high only in ISSUE
//   mem_rdata                 : memory read data, valid MEM_LAT cycles after mem_en
//   busy                      : FSM not in IDLE
module data_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("data_mem_arbiter: MEM_LAT must be >= 1");
  end

  localparam int unsigned CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  mem_state_t        state_q, state_d;
  logic              last_grant;
  logic [1:0]        grant;
  logic              accept;
  logic              acc_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              req_we;
  logic              req_port;
  logic [CNT_W-1:0]  cnt;
  logic              wait_last;

  rr_arbiter2 #(.PRIO_FIXED(PRIO_FIXED)) u_rr (
    .valid      ({r1_valid, r0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign r0_ready  = (state_q == IDLE) && r0_valid && grant[0];
  assign r1_ready  = (state_q == IDLE) && r1_valid && grant[1];
  assign accept    = r0_ready || r1_ready;
  assign acc_port  = r1_ready ? PORT_DBG : PORT_CORE;
  assign sel_we    = r1_ready ? r1_we    : r0_we;
  assign sel_addr  = r1_ready ? r1_addr  : r0_addr;
  assign sel_wdata = r1_ready ? r1_wdata : r0_wdata;
  assign wait_last = (state_q == WAIT) && (cnt == LAST_CNT);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = req_we ? IDLE : WAIT;
      WAIT:    if (wait_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_* are loaded on the accepting edge so they are valid for exactly the
  // ISSUE cycle, and fall back to zero on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_grant <= PORT_DBG;
      req_we     <= 1'b0;
      req_port   <= PORT_CORE;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q   <= state_d;
      cnt       <= (state_q == WAIT) ? cnt + 1'b1 : '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if (accept) begin
        last_grant <= acc_port;
        req_we     <= sel_we;
        req_port   <= acc_port;
        mem_en     <= 1'b1;
        mem_we     <= sel_we;
        mem_addr   <= sel_addr;
        mem_wdata  <= sel_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= wait_last && (req_port == PORT_CORE);
      r1_rvalid <= wait_last && (req_port == PORT_DBG);
      if (wait_last) begin
        if (req_port == PORT_CORE) r0_rdata <= mem_rdata;
        else                       r1_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 64;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance
  logic          r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  // fixed-priority instance (grant order only)
  logic          b_r0_valid, b_r0_ready, b_r0_rvalid;
  logic          b_r1_valid, b_r1_ready, b_r1_rvalid;
  logic [DW-1:0] b_r0_rdata, b_r1_rdata;
  logic          b_mem_en, b_mem_we, b_busy;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .PRIO_FIXED(0)) u_dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .PRIO_FIXED(1)) u_dut_fixed (
    .clk(clk), .reset(reset),
    .r0_valid(b_r0_valid), .r0_ready(b_r0_ready), .r0_we(1'b0), .r0_addr(8'h01),
    .r0_wdata('0), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
    .r1_valid(b_r1_valid), .r1_ready(b_r1_ready), .r1_we(1'b0), .r1_addr(8'h02),
    .r1_wdata('0), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata('0), .busy(b_busy)
  );

  // memory macro: read data appears LAT(=2) cycles after the mem_en cycle
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] mem_p1 = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_p1 <= mem[mem_addr];
    end
    mem_rdata <= mem_p1;
  end

  // bench reference contents
  logic [DW-1:0] ref_mem [0:255];

  int unsigned n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int unsigned men_cnt = 0;
  logic        acc_port[$];
  int unsigned acc_cyc[$];
  logic        bacc_port[$];
  int unsigned bacc_cyc[$];

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (r0_rvalid || r1_rvalid) begin
      if (sbq.size() == 0) chk("rv_unexpected", {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("rv_port",  {63'd0, r1_rvalid}, {63'd0, e.port});
        chk("rv_cycle", 64'(cyc), 64'(e.due));
        chk("rv_data",  r1_rvalid ? r1_rdata : r0_rdata, e.data);
      end
    end
    if (mem_en) men_cnt++;
    if (r0_valid && r0_ready) begin
      acc_port.push_back(1'b0);
      acc_cyc.push_back(cyc);
      if (r0_we) ref_mem[r0_addr] = r0_wdata;
      else begin
        e.port = 1'b0; e.data = ref_mem[r0_addr]; e.due = cyc + 2 + LAT;
        sbq.push_back(e);
      end
    end
    if (r1_valid && r1_ready) begin
      acc_port.push_back(1'b1);
      acc_cyc.push_back(cyc);
      if (r1_we) ref_mem[r1_addr] = r1_wdata;
      else begin
        e.port = 1'b1; e.data = ref_mem[r1_addr]; e.due = cyc + 2 + LAT;
        sbq.push_back(e);
      end
    end
    if (b_r0_valid && b_r0_ready) begin bacc_port.push_back(1'b0); bacc_cyc.push_back(cyc); end
    if (b_r1_valid && b_r1_ready) begin bacc_port.push_back(1'b1); bacc_cyc.push_back(cyc); end
  end

  task automatic req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic got;
    @(posedge clk); #1;
    if (p == 0) begin r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; end
    else        begin r1_valid = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; end
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((p == 0) ? r0_ready : r1_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    // payload scrambled after acceptance must not matter
    if (p == 0) begin r0_valid = 1'b0; r0_addr = ~a; r0_wdata = ~d; r0_we = ~we; end
    else        begin r1_valid = 1'b0; r1_addr = ~a; r1_wdata = ~d; r1_we = ~we; end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned m0;
    int unsigned n1;
    logic        got;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 64'h1000 + 64'(i);
      ref_mem[i] = 64'h1000 + 64'(i);
    end
    mem[8'h10]     = 64'hDEADBEEF;
    ref_mem[8'h10] = 64'hDEADBEEF;
    r0_valid = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    b_r0_valid = 0; b_r1_valid = 0;

    // 1: reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   {63'd0, busy}, 64'd0);
    chk("rst_mem",    {61'd0, mem_en, mem_we, |mem_addr}, 64'd0);
    chk("rst_wdata",  mem_wdata, 64'd0);
    chk("rst_rvalid", {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
    chk("rst_rdata",  r0_rdata | r1_rdata, 64'd0);
    chk("rst_ready",  {62'd0, r1_ready, r0_ready}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_idle", {61'd0, busy, mem_en, r0_rvalid | r1_rvalid}, 64'd0);

    // 2: single read, fixed latency
    req(0, 1'b0, 8'h10, '0);
    @(negedge clk);
    chk("t2_mem_en",   {63'd0, mem_en}, 64'd1);
    chk("t2_mem_we",   {63'd0, mem_we}, 64'd0);
    chk("t2_mem_addr", {56'd0, mem_addr}, 64'h10);
    chk("t2_busy",     {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("t2_mem_en_off", {63'd0, mem_en}, 64'd0);
    idle_cycles(6);
    chk("t2_drained",  64'(sbq.size()), 64'd0);
    chk("t2_rdata_hold", r0_rdata, 64'hDEADBEEF);

    // 3: both ports hold reads: RR alternates, fixed priority keeps port 0
    acc_port.delete(); acc_cyc.delete(); bacc_port.delete(); bacc_cyc.delete();
    @(posedge clk); #1;
    r0_valid = 1; r0_we = 0; r0_addr = 8'h20;
    r1_valid = 1; r1_we = 0; r1_addr = 8'h21;
    b_r0_valid = 1; b_r1_valid = 1;
    repeat (22) @(posedge clk);
    #1;
    r0_valid = 0; r1_valid = 0; b_r0_valid = 0;
    chk("t3_rr_count", 64'(acc_port.size()), 64'd5);
    for (int i = 0; i < acc_port.size() && i < 5; i++) begin
      chk("t3_rr_port", {63'd0, acc_port[i]}, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("t3_rr_gap",  64'(acc_cyc[i] - acc_cyc[0]), 64'(5 * i));
    end
    chk("t3_fx_count", 64'(bacc_port.size()), 64'd5);
    for (int i = 0; i < bacc_port.size() && i < 5; i++) begin
      chk("t3_fx_port", {63'd0, bacc_port[i]}, 64'd0);
      chk("t3_fx_gap",  64'(bacc_cyc[i] - bacc_cyc[0]), 64'(5 * i));
    end
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_r1_ready) begin got = 1'b1; break; end
    end
    chk("t3_fx_r1_served", {63'd0, got}, 64'd1);
    @(posedge clk); #1 b_r1_valid = 0;
    idle_cycles(8);
    chk("t3_drained", 64'(sbq.size()), 64'd0);

    // 4: write on port 1 then read it back on port 0
    req(1, 1'b1, 8'h08, 64'd5);
    @(negedge clk);
    chk("t4_mem_en",    {63'd0, mem_en}, 64'd1);
    chk("t4_mem_we",    {63'd0, mem_we}, 64'd1);
    chk("t4_mem_addr",  {56'd0, mem_addr}, 64'h08);
    chk("t4_mem_wdata", mem_wdata, 64'd5);
    @(negedge clk);
    chk("t4_idle_c2",   {62'd0, busy, mem_en}, 64'd0);
    req(0, 1'b0, 8'h08, '0);
    idle_cycles(6);
    chk("t4_readback", r0_rdata, 64'd5);
    chk("t4_drained",  64'(sbq.size()), 64'd0);

    // 5: reset during WAIT aborts the read
    req(0, 1'b0, 8'h30, '0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_wait", {63'd0, busy}, 64'd1);
    #1 reset = 1'b0;
    #1;
    sbq.delete();
    chk("t5_abort_out", {60'd0, busy, mem_en, r0_rvalid, r1_rvalid}, 64'd0);
    chk("t5_abort_rdata", r0_rdata, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(6);
    chk("t5_no_rv", 64'(sbq.size()), 64'd0);
    req(0, 1'b0, 8'h10, '0);
    idle_cycles(6);
    chk("t5_next_rdata", r0_rdata, 64'hDEADBEEF);
    chk("t5_drained", 64'(sbq.size()), 64'd0);

    // 6: r1 pulsed while busy is dropped without any access
    acc_port.delete(); acc_cyc.delete();
    m0 = men_cnt;
    req(0, 1'b0, 8'h11, '0);
    r1_valid = 1; r1_we = 1; r1_addr = 8'h40; r1_wdata = 64'h77;
    @(negedge clk);
    chk("t6_r1_ready_busy", {63'd0, r1_ready}, 64'd0);
    @(posedge clk); #1 r1_valid = 0;
    idle_cycles(8);
    chk("t6_mem_en_count", 64'(men_cnt - m0), 64'd1);
    n1 = 0;
    foreach (acc_port[i]) if (acc_port[i]) n1++;
    chk("t6_r1_accepts", 64'(n1), 64'd0);
    chk("t6_drained", 64'(sbq.size()), 64'd0);
    chk("t6_mem40_untouched", mem[8'h40], 64'h1040);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
